// File: rtl/ltc_2656_rx_model.sv
// rtl/ltc_2656_rx_model.sv - LTC-2656 DAC serial port and register file receiver model
// Pins are synchronized to clk; frames are shifted on sck and executed on csld rising.
module ltc_2656_rx_model #(
  parameter int SYNC_STAGES  = 2,
  parameter bit CLR_MIDSCALE = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sck,
  input  logic        sdi,
  input  logic        csld,
  input  logic        ldac_n,
  input  logic        clr_n,
  input  logic [2:0]  rd_channel,
  output logic [15:0] rd_input,
  output logic [15:0] rd_dac,
  output logic [7:0]  pd_mask,
  output logic        int_ref,
  output logic [7:0]  dac_changed,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_cmd,
  output logic [3:0]  frame_addr,
  output logic [15:0] frame_data
);

  localparam logic [15:0] CLR_VAL  = CLR_MIDSCALE ? 16'h8000 : 16'h0000;
  // pin order {sck, sdi, csld, ldac_n, clr_n}; idle levels avoid spurious edges after reset
  localparam logic [4:0]  PIN_IDLE = 5'b00111;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_EXEC} state_t;

  logic [4:0]  sync_q [SYNC_STAGES];
  logic [4:0]  pin_prev;
  logic [4:0]  pin_s;
  logic        sck_rise, csld_fall, csld_rise, ldac_fall, clr_low;
  state_t      state_q, state_d;
  logic [23:0] shifter;
  logic [5:0]  bit_cnt;
  logic [15:0] in_q  [8];
  logic [15:0] in_d  [8];
  logic [15:0] dac_q [8];
  logic [15:0] dac_d [8];
  logic [7:0]  pd_d, chg_d, sel;
  logic        ref_d, exec, legal;
  logic [3:0]  cmd, addr;
  logic [15:0] data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
      pin_prev <= PIN_IDLE;
    end else begin
      sync_q[0] <= {sck, sdi, csld, ldac_n, clr_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pin_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pin_s     = sync_q[SYNC_STAGES-1];
  assign sck_rise  = pin_s[4] & ~pin_prev[4];
  assign csld_fall = ~pin_s[2] & pin_prev[2];
  assign csld_rise = pin_s[2] & ~pin_prev[2];
  assign ldac_fall = ~pin_s[1] & pin_prev[1];
  assign clr_low   = ~pin_s[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (csld_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (csld_rise) state_d = ST_EXEC;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shifter <= '0;
      bit_cnt <= '0;
    end else if (state_q == ST_IDLE && csld_fall) begin
      shifter <= '0;
      bit_cnt <= '0;
    end else if (state_q == ST_SHIFT && sck_rise) begin
      shifter <= {shifter[22:0], pin_s[3]};
      if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
    end
  end

  assign exec  = (state_q == ST_EXEC);
  assign legal = (bit_cnt >= 6'd24) && (bit_cnt <= 6'd32);
  assign cmd   = shifter[23:20];
  assign addr  = shifter[19:16];
  assign data  = shifter[15:0];

  always_comb begin
    sel = 8'h00;
    if (addr == 4'hF)    sel = 8'hFF;
    else if (!addr[3])   sel = 8'h01 << addr[2:0];
  end

  // Command effects first, then an ldac edge copies the result, then clr overrides all.
  always_comb begin
    in_d  = in_q;
    dac_d = dac_q;
    pd_d  = pd_mask;
    ref_d = int_ref;
    chg_d = 8'h00;
    if (exec && legal && !clr_low && sel != 8'h00) begin
      case (cmd)
        4'h0: for (int n = 0; n < 8; n++) if (sel[n]) in_d[n] = data;
        4'h1: begin
          for (int n = 0; n < 8; n++) if (sel[n]) dac_d[n] = in_q[n];
          chg_d = sel;
          pd_d  = pd_mask & ~sel;
        end
        4'h2: begin
          for (int n = 0; n < 8; n++) begin
            if (sel[n]) in_d[n] = data;
            dac_d[n] = in_d[n];
          end
          chg_d = 8'hFF;
          pd_d  = 8'h00;
        end
        4'h3: begin
          for (int n = 0; n < 8; n++) if (sel[n]) begin
            in_d[n]  = data;
            dac_d[n] = data;
          end
          chg_d = sel;
          pd_d  = pd_mask & ~sel;
        end
        4'h4: pd_d  = pd_mask | sel;
        4'h5: pd_d  = 8'hFF;
        4'h6: ref_d = 1'b1;
        4'h7: ref_d = 1'b0;
        default: ;
      endcase
    end
    if (ldac_fall && !clr_low) begin
      for (int n = 0; n < 8; n++) dac_d[n] = in_d[n];
      chg_d = 8'hFF;
      pd_d  = 8'h00;
    end
    if (clr_low) begin
      for (int n = 0; n < 8; n++) begin
        in_d[n]  = CLR_VAL;
        dac_d[n] = CLR_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 8; n++) begin
        in_q[n]  <= '0;
        dac_q[n] <= '0;
      end
      pd_mask     <= 8'h00;
      int_ref     <= 1'b1;
      dac_changed <= 8'h00;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
      rd_input    <= '0;
      rd_dac      <= '0;
    end else begin
      in_q        <= in_d;
      dac_q       <= dac_d;
      pd_mask     <= pd_d;
      int_ref     <= ref_d;
      dac_changed <= chg_d;
      frame_valid <= exec && legal;
      frame_err   <= exec && !legal;
      if (exec && legal) begin
        frame_cmd  <= cmd;
        frame_addr <= addr;
        frame_data <= data;
      end
      rd_input <= in_q[rd_channel];
      rd_dac   <= dac_q[rd_channel];
    end
  end

endmodule

// File: tb/tb_ltc_2656_rx_model.sv
// tb/tb_ltc_2656_rx_model.sv - directed bench for ltc_2656_rx_model
module tb_ltc_2656_rx_model;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sck = 1'b0, sdi = 1'b0, csld = 1'b1, ldac_n = 1'b1, clr_n = 1'b1;
  logic [2:0]  rd_channel = 3'd0;
  logic [15:0] rd_input, rd_dac, frame_data;
  logic [7:0]  pd_mask, dac_changed;
  logic        int_ref, frame_valid, frame_err;
  logic [3:0]  frame_cmd, frame_addr;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0, err_cnt = 0, chg_cnt = 0;
  logic [7:0] chg_last = 8'h00;
  int v0, e0, c0;
  logic [15:0] ri, rdv;

  ltc_2656_rx_model #(.SYNC_STAGES(2), .CLR_MIDSCALE(1'b1)) dut (
    .clk(clk), .resetn(resetn), .sck(sck), .sdi(sdi), .csld(csld), .ldac_n(ldac_n),
    .clr_n(clr_n), .rd_channel(rd_channel), .rd_input(rd_input), .rd_dac(rd_dac),
    .pd_mask(pd_mask), .int_ref(int_ref), .dac_changed(dac_changed),
    .frame_valid(frame_valid), .frame_err(frame_err), .frame_cmd(frame_cmd),
    .frame_addr(frame_addr), .frame_data(frame_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) valid_cnt <= valid_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (dac_changed != 8'h00) begin
      chg_cnt  <= chg_cnt + 1;
      chg_last <= dac_changed;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    v0 = valid_cnt; e0 = err_cnt; c0 = chg_cnt;
  endtask

  // clr_bit >= 0 drives clr_n low just before that bit is shifted
  task automatic send_frame(input logic [63:0] bits, input int n, input int clr_bit);
    snap();
    csld = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      if (i == clr_bit) clr_n = 1'b0;
      sdi = bits[i];
      tick(3);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(1);
    end
    tick(4);
    csld = 1'b1;
    tick(10);
  endtask

  task automatic read_ch(input int ch, output logic [15:0] vin, output logic [15:0] vdac);
    rd_channel = ch[2:0];
    tick(2);
    vin = rd_input;
    vdac = rd_dac;
  endtask

  task automatic test_reset();
    for (int ch = 0; ch < 8; ch += 7) begin
      read_ch(ch, ri, rdv);
      total++;
      if (ri !== 16'h0 || rdv !== 16'h0) begin
        bad++; $display("FAIL reset_regs ch%0d: got in=%h dac=%h want 0/0", ch, ri, rdv);
      end
    end
    total++;
    if (pd_mask !== 8'h00 || int_ref !== 1'b1 || dac_changed !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got pd=%h ref=%b chg=%h want 00/1/00", pd_mask, int_ref, dac_changed);
    end
    total++;
    if (frame_cmd !== 4'h0 || frame_addr !== 4'h0 || frame_data !== 16'h0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL reset_frame: got cmd=%h addr=%h data=%h v=%b e=%b want zeros", frame_cmd, frame_addr, frame_data, frame_valid, frame_err);
    end
  endtask

  task automatic test_write_update();
    send_frame(64'h32ABCD, 24, -1);
    read_ch(2, ri, rdv);
    total++;
    if (ri !== 16'hABCD || rdv !== 16'hABCD) begin
      bad++; $display("FAIL wu_regs: got in=%h dac=%h want abcd/abcd", ri, rdv);
    end
    total++;
    if (valid_cnt - v0 !== 1 || chg_cnt - c0 !== 1 || chg_last !== 8'h04) begin
      bad++; $display("FAIL wu_pulses: got valid=%0d chg=%0d mask=%h want 1/1/04", valid_cnt - v0, chg_cnt - c0, chg_last);
    end
    total++;
    if (frame_cmd !== 4'h3 || frame_addr !== 4'h2 || frame_data !== 16'hABCD) begin
      bad++; $display("FAIL wu_frame: got %h %h %h want 3 2 abcd", frame_cmd, frame_addr, frame_data);
    end
  endtask

  task automatic test_ldac();
    send_frame(64'h0F1234, 24, -1);
    total++;
    if (chg_cnt - c0 !== 0) begin
      bad++; $display("FAIL ldac_pre_chg: got %0d pulses want 0", chg_cnt - c0);
    end
    for (int ch = 0; ch < 8; ch++) begin
      read_ch(ch, ri, rdv);
      total++;
      if (ri !== 16'h1234 || rdv !== ((ch == 2) ? 16'hABCD : 16'h0000)) begin
        bad++; $display("FAIL ldac_pre ch%0d: got in=%h dac=%h", ch, ri, rdv);
      end
    end
    snap();
    ldac_n = 1'b0;
    tick(4);
    ldac_n = 1'b1;
    tick(6);
    total++;
    if (chg_cnt - c0 !== 1 || chg_last !== 8'hFF) begin
      bad++; $display("FAIL ldac_chg: got %0d pulses mask=%h want 1/ff", chg_cnt - c0, chg_last);
    end
    for (int ch = 0; ch < 8; ch++) begin
      read_ch(ch, ri, rdv);
      total++;
      if (rdv !== 16'h1234) begin
        bad++; $display("FAIL ldac_post ch%0d: got dac=%h want 1234", ch, rdv);
      end
    end
  endtask

  task automatic test_bad_length();
    send_frame(64'h305555, 23, -1);
    total++;
    if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
      bad++; $display("FAIL short_pulses: got err=%0d valid=%0d want 1/0", err_cnt - e0, valid_cnt - v0);
    end
    send_frame(64'h1_0F5555, 33, -1);
    total++;
    if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0 || chg_cnt - c0 !== 0) begin
      bad++; $display("FAIL long_pulses: got err=%0d valid=%0d chg=%0d want 1/0/0", err_cnt - e0, valid_cnt - v0, chg_cnt - c0);
    end
    read_ch(0, ri, rdv);
    total++;
    if (ri !== 16'h1234 || rdv !== 16'h1234 || frame_cmd !== 4'h0 || frame_addr !== 4'hF || frame_data !== 16'h1234) begin
      bad++; $display("FAIL badlen_state: got in=%h dac=%h frame=%h%h%h want 1234/1234/0f1234", ri, rdv, frame_cmd, frame_addr, frame_data);
    end
  endtask

  task automatic test_32bit_frame();
    send_frame(64'hFF310001, 32, -1);
    read_ch(1, ri, rdv);
    total++;
    if (ri !== 16'h0001 || rdv !== 16'h0001 || chg_last !== 8'h02 || valid_cnt - v0 !== 1) begin
      bad++; $display("FAIL f32: got in=%h dac=%h chg=%h valid=%0d want 0001/0001/02/1", ri, rdv, chg_last, valid_cnt - v0);
    end
    total++;
    if (frame_cmd !== 4'h3 || frame_addr !== 4'h1 || frame_data !== 16'h0001) begin
      bad++; $display("FAIL f32_frame: got %h %h %h want 3 1 0001", frame_cmd, frame_addr, frame_data);
    end
  endtask

  task automatic test_power_ref();
    send_frame(64'h450000, 24, -1);
    total++;
    if (pd_mask !== 8'h20) begin
      bad++; $display("FAIL pd_set: got %h want 20", pd_mask);
    end
    send_frame(64'h350010, 24, -1);
    read_ch(5, ri, rdv);
    total++;
    if (pd_mask !== 8'h00 || rdv !== 16'h0010) begin
      bad++; $display("FAIL pd_clear: got pd=%h dac=%h want 00/0010", pd_mask, rdv);
    end
    send_frame(64'h7F0000, 24, -1);
    total++;
    if (int_ref !== 1'b0) begin
      bad++; $display("FAIL ref_ext: got %b want 0", int_ref);
    end
    send_frame(64'h6F0000, 24, -1);
    total++;
    if (int_ref !== 1'b1) begin
      bad++; $display("FAIL ref_int: got %b want 1", int_ref);
    end
  endtask

  task automatic test_invalid_addr();
    send_frame(64'h387777, 24, -1);
    read_ch(0, ri, rdv);
    total++;
    if (valid_cnt - v0 !== 1 || chg_cnt - c0 !== 0 || frame_addr !== 4'h8 || ri !== 16'h1234) begin
      bad++; $display("FAIL bad_addr: got valid=%0d chg=%0d addr=%h in=%h want 1/0/8/1234", valid_cnt - v0, chg_cnt - c0, frame_addr, ri);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(64'h001111, 24, -1);
    read_ch(0, ri, rdv);
    total++;
    if (ri !== 16'h1111 || rdv !== 16'h1234) begin
      bad++; $display("FAIL b2b_write: got in=%h dac=%h want 1111/1234", ri, rdv);
    end
    send_frame(64'h100000, 24, -1);
    read_ch(0, ri, rdv);
    total++;
    if (rdv !== 16'h1111 || chg_last !== 8'h01 || chg_cnt - c0 !== 1) begin
      bad++; $display("FAIL b2b_update: got dac=%h chg=%h n=%0d want 1111/01/1", rdv, chg_last, chg_cnt - c0);
    end
  endtask

  task automatic test_clear();
    send_frame(64'h349999, 24, 10);
    total++;
    if (valid_cnt - v0 !== 1 || frame_data !== 16'h9999 || frame_addr !== 4'h4 || chg_cnt - c0 !== 0) begin
      bad++; $display("FAIL clr_frame: got valid=%0d data=%h addr=%h chg=%0d want 1/9999/4/0", valid_cnt - v0, frame_data, frame_addr, chg_cnt - c0);
    end
    clr_n = 1'b1;
    tick(6);
    for (int ch = 0; ch < 8; ch++) begin
      read_ch(ch, ri, rdv);
      total++;
      if (ri !== 16'h8000 || rdv !== 16'h8000) begin
        bad++; $display("FAIL clr_regs ch%0d: got in=%h dac=%h want 8000/8000", ch, ri, rdv);
      end
    end
  endtask

  initial begin
    tick(3);
    resetn = 1'b1;
    tick(4);
    test_reset();
    test_write_update();
    test_ldac();
    test_bad_length();
    test_32bit_frame();
    test_power_ref();
    test_invalid_addr();
    test_back_to_back();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
